// File: rtl/parallel_stream_engine.sv
// Streaming copy/transform engine: reads a job descriptor over the register port, streams
// N words from input memory through an in-order FIFO to output memory, then reports the count.
// Optional STREAM_LED_STATUS_EN drives LED with state and progress.
module parallel_stream_engine #(
    parameter int DATA_W     = 32,
    parameter int IN_AW      = 17,
    parameter int OUT_AW     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                userRunValue,
    output logic                userRunClear,
    output logic                register32CmdReq,
    input  logic                register32CmdAck,
    output logic [31:0]         register32WriteData,
    output logic [7:0]          register32Address,
    output logic                register32WriteEn,
    input  logic                register32ReadDataValid,
    input  logic [31:0]         register32ReadData,
    output logic                inputMemoryReadReq,
    input  logic                inputMemoryReadAck,
    output logic [IN_AW-1:0]    inputMemoryReadAdd,
    input  logic                inputMemoryReadDataValid,
    input  logic [DATA_W-1:0]   inputMemoryReadData,
    output logic                outputMemoryWriteReq,
    input  logic                outputMemoryWriteAck,
    output logic [OUT_AW-1:0]   outputMemoryWriteAdd,
    output logic [DATA_W-1:0]   outputMemoryWriteData,
    output logic [DATA_W/8-1:0] outputMemoryWriteByteMask,
    output logic [7:0]          LED
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CFG  = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STAT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]        r_state;
    logic              r_cmd_req, r_cmd_we, r_rd_wait;
    logic [7:0]        r_cmd_addr;
    logic [31:0]       r_cmd_wdata;
    logic [31:0]       r_n;
    logic [IN_AW-1:0]  r_src;
    logic [OUT_AW-1:0] r_dst;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_k;
    logic [31:0]       r_issued, r_popped, r_written;
    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_cnt;
    logic              r_wr_req;
    logic [OUT_AW-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data, r_sum;

    logic              w_rd_req, w_rd_fire, w_push, w_pop, w_wr_done;
    logic [DATA_W-1:0] w_head, w_sum_nxt, w_f;

    // Read issue only depends on registered state, so Req/Add cannot move before Ack.
    // Acked-but-unpopped reads are bounded by FIFO_DEPTH, so a return always finds room.
    assign w_rd_req  = (r_state == ST_RUN) && (r_issued < r_n) &&
                       ((r_issued - r_popped) < 32'(FIFO_DEPTH));
    assign w_rd_fire = w_rd_req && inputMemoryReadAck;
    assign w_push    = (r_state == ST_RUN) && inputMemoryReadDataValid;
    assign w_wr_done = r_wr_req && outputMemoryWriteAck;
    assign w_pop     = (r_state == ST_RUN) && (r_cnt != '0) && (!r_wr_req || outputMemoryWriteAck);
    assign w_head    = r_fifo[r_rptr];
    assign w_sum_nxt = r_sum + w_head;

    always_comb begin
        w_f = w_head;
        case (r_mode)
            2'd1:    w_f = w_head + r_k;
            2'd2:    w_f = w_sum_nxt;
            2'd3:    w_f = w_head ^ r_k;
            default: w_f = w_head;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= inputMemoryReadData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cmd_req   <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_n         <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_mode      <= '0;
            r_k         <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_written   <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (userRunValue) begin
                    r_state    <= ST_CFG;
                    r_cmd_req  <= 1'b1;
                    r_cmd_we   <= 1'b0;
                    r_cmd_addr <= 8'd0;
                    r_rd_wait  <= 1'b0;
                    r_issued   <= '0;
                    r_popped   <= '0;
                    r_written  <= '0;
                    r_sum      <= '0;
                    r_cnt      <= '0;
                    r_wptr     <= '0;
                    r_rptr     <= '0;
                end
                ST_CFG: begin
                    if (r_cmd_req && register32CmdAck) begin
                        r_cmd_req <= 1'b0;
                        r_rd_wait <= 1'b1;
                    end else if (r_rd_wait && register32ReadDataValid) begin
                        r_rd_wait <= 1'b0;
                        case (r_cmd_addr[1:0])
                            2'd0:    r_n   <= register32ReadData;
                            2'd1:    r_src <= IN_AW'(register32ReadData);
                            2'd2:    r_dst <= OUT_AW'(register32ReadData);
                            default: begin
                                r_mode <= register32ReadData[1:0];
                                r_k    <= DATA_W'(register32ReadData[31:16]);
                            end
                        endcase
                        if (r_cmd_addr == 8'd3) begin
                            // An empty job skips straight to the status write.
                            if (r_n == 32'd0) begin
                                r_state     <= ST_STAT;
                                r_cmd_req   <= 1'b1;
                                r_cmd_we    <= 1'b1;
                                r_cmd_addr  <= 8'd4;
                                r_cmd_wdata <= r_written;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_cmd_req  <= 1'b1;
                            r_cmd_addr <= r_cmd_addr + 8'd1;
                        end
                    end
                end
                ST_RUN: if (w_wr_done && (r_written == r_n - 32'd1)) begin
                    r_state     <= ST_STAT;
                    r_cmd_req   <= 1'b1;
                    r_cmd_we    <= 1'b1;
                    r_cmd_addr  <= 8'd4;
                    r_cmd_wdata <= r_written + 32'd1;
                end
                ST_STAT: if (register32CmdAck) begin
                    r_state     <= ST_DONE;
                    r_cmd_req   <= 1'b0;
                    r_cmd_we    <= 1'b0;
                    r_cmd_addr  <= '0;
                    r_cmd_wdata <= '0;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_rd_fire) r_issued <= r_issued + 32'd1;
            if (w_push)    r_wptr   <= r_wptr + PW'(1);
            if (w_wr_done) r_written <= r_written + 32'd1;
            if (w_pop) begin
                r_rptr    <= r_rptr + PW'(1);
                r_popped  <= r_popped + 32'd1;
                r_wr_req  <= 1'b1;
                r_wr_addr <= r_dst + OUT_AW'(r_popped);
                r_wr_data <= w_f;
                r_sum     <= w_sum_nxt;
            end else if (w_wr_done) begin
                r_wr_req <= 1'b0;
            end
            if (w_push || w_pop) r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign userRunClear              = (r_state == ST_DONE);
    assign register32CmdReq          = r_cmd_req;
    assign register32WriteData       = r_cmd_wdata;
    assign register32Address         = r_cmd_addr;
    assign register32WriteEn         = r_cmd_we;
    assign inputMemoryReadReq        = w_rd_req;
    assign inputMemoryReadAdd        = w_rd_req ? (r_src + IN_AW'(r_issued)) : '0;
    assign outputMemoryWriteReq      = r_wr_req;
    assign outputMemoryWriteAdd      = r_wr_addr;
    assign outputMemoryWriteData     = r_wr_data;
    assign outputMemoryWriteByteMask = '1;

`ifdef STREAM_LED_STATUS_EN
    assign LED = {r_written[4:0], r_state};
`else
    assign LED = 8'd0;
`endif
endmodule

// File: tb/tb_parallel_stream_engine.sv
// Bench for parallel_stream_engine: register/memory responders on the falling edge,
// expected reads/writes queued per job and popped as the DUT issues them.
module tb_parallel_stream_engine;
    localparam int DATA_W = 32, IN_AW = 17, OUT_AW = 13, FIFO_DEPTH = 4;
    localparam int INMASK = (1 << IN_AW) - 1, OUTMASK = (1 << OUT_AW) - 1;

    logic clk = 1'b0, reset = 1'b0, userRunValue = 1'b0, userRunClear;
    logic register32CmdReq, register32CmdAck = 1'b0, register32WriteEn;
    logic [31:0] register32WriteData, register32ReadData = '0;
    logic [7:0] register32Address, LED;
    logic register32ReadDataValid = 1'b0;
    logic inputMemoryReadReq, inputMemoryReadAck = 1'b0, inputMemoryReadDataValid = 1'b0;
    logic [IN_AW-1:0] inputMemoryReadAdd;
    logic [DATA_W-1:0] inputMemoryReadData = '0;
    logic outputMemoryWriteReq, outputMemoryWriteAck = 1'b0;
    logic [OUT_AW-1:0] outputMemoryWriteAdd;
    logic [DATA_W-1:0] outputMemoryWriteData;
    logic [DATA_W/8-1:0] outputMemoryWriteByteMask;

    parallel_stream_engine #(.DATA_W(DATA_W), .IN_AW(IN_AW), .OUT_AW(OUT_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .userRunValue(userRunValue), .userRunClear(userRunClear),
        .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
        .register32WriteData(register32WriteData), .register32Address(register32Address),
        .register32WriteEn(register32WriteEn), .register32ReadDataValid(register32ReadDataValid),
        .register32ReadData(register32ReadData), .inputMemoryReadReq(inputMemoryReadReq),
        .inputMemoryReadAck(inputMemoryReadAck), .inputMemoryReadAdd(inputMemoryReadAdd),
        .inputMemoryReadDataValid(inputMemoryReadDataValid), .inputMemoryReadData(inputMemoryReadData),
        .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
        .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
        .outputMemoryWriteByteMask(outputMemoryWriteByteMask), .LED(LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n; int src; int dst; int mode; int k; bit slow;
        int exp_reg4; int exp_clears;
    } job_t;
    typedef struct { int addr; logic [31:0] data; } wr_t;

    int checks = 0, errors = 0;
    wr_t wr_q[$];
    int rd_q[$];
    int rd_log[$];
    logic [31:0] out_log [int];
    logic [31:0] ovr [int];
    logic [31:0] cfg [4];
    bit slow = 1'b0;

    // Responder/monitor state, owned by the falling-edge process.
    int cyc = 0, rd_acked = 0, wr_acked = 0, clears = 0, viol = 0, max_out = 0;
    int reg4_writes = 0, reg4_addr = 0, first_wr = -1, last_wr = -1, rd_wait = 0;
    logic [31:0] reg4_val = '0;
    bit rd_pend = 0, wr_pend = 0, cmd_pend = 0, rd_fire_prev = 0, cmd_rd_prev = 0;
    int rd_pend_addr = 0, wr_pend_addr = 0, rd_prev_addr = 0;
    logic [31:0] wr_pend_data = '0;
    logic [7:0] cmd_pend_addr = '0, cmd_prev_addr = '0;
    logic cmd_pend_we = 1'b0;

    function automatic logic [31:0] mem_word(input int a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                inputMemoryReadDataValid = 1'b0;
                register32ReadDataValid  = 1'b0;
                rd_fire_prev = 0; cmd_rd_prev = 0;
                rd_pend = 0; wr_pend = 0; cmd_pend = 0; rd_wait = 0;
                continue;
            end
            // Anything requested but not accepted last cycle must be held unchanged.
            if (rd_pend && !(inputMemoryReadReq && int'(inputMemoryReadAdd) == rd_pend_addr)) viol++;
            if (wr_pend && !(outputMemoryWriteReq && int'(outputMemoryWriteAdd) == wr_pend_addr &&
                             outputMemoryWriteData == wr_pend_data)) viol++;
            if (cmd_pend && !(register32CmdReq && register32Address == cmd_pend_addr &&
                              register32WriteEn == cmd_pend_we)) viol++;

            inputMemoryReadDataValid = rd_fire_prev;
            inputMemoryReadData      = rd_fire_prev ? mem_word(rd_prev_addr) : '0;
            register32ReadDataValid  = cmd_rd_prev;
            register32ReadData       = cmd_rd_prev ? cfg[cmd_prev_addr[1:0]] : '0;

            if (inputMemoryReadReq || outputMemoryWriteReq) begin
                int o;
                o = rd_acked - (wr_acked + int'(outputMemoryWriteReq)) + int'(inputMemoryReadReq);
                if (o > max_out) max_out = o;
            end

            if (slow) begin
                if (inputMemoryReadReq) begin
                    inputMemoryReadAck = (rd_wait == 3);
                    rd_wait = inputMemoryReadAck ? 0 : rd_wait + 1;
                end else begin
                    inputMemoryReadAck = 1'b0;
                    rd_wait = 0;
                end
                outputMemoryWriteAck = 1'($urandom_range(0, 1));
                register32CmdAck     = 1'($urandom_range(0, 1));
            end else begin
                inputMemoryReadAck = 1'b1; outputMemoryWriteAck = 1'b1; register32CmdAck = 1'b1;
            end

            rd_fire_prev = inputMemoryReadReq && inputMemoryReadAck;
            rd_prev_addr = int'(inputMemoryReadAdd);
            if (rd_fire_prev) begin
                rd_acked++;
                rd_log.push_back(rd_prev_addr);
                if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_prev_addr), 64'hFFFF_FFFF);
                else chk("rd_addr", 64'(rd_prev_addr), 64'(rd_q.pop_front()));
            end
            if (outputMemoryWriteReq && outputMemoryWriteAck) begin
                wr_t e;
                wr_acked++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                out_log[int'(outputMemoryWriteAdd)] = outputMemoryWriteData;
                if (wr_q.size() == 0) chk("wr_unexpected", 64'(outputMemoryWriteAdd), 64'hFFFF_FFFF);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 64'(outputMemoryWriteAdd), 64'(e.addr));
                    chk("wr_data", 64'(outputMemoryWriteData), 64'(e.data));
                end
            end
            cmd_rd_prev   = register32CmdReq && register32CmdAck && !register32WriteEn;
            cmd_prev_addr = register32Address;
            if (register32CmdReq && register32CmdAck && register32WriteEn) begin
                reg4_writes++;
                reg4_val  = register32WriteData;
                reg4_addr = int'(register32Address);
            end
            if (userRunClear) clears++;

            rd_pend = inputMemoryReadReq && !inputMemoryReadAck;
            rd_pend_addr = int'(inputMemoryReadAdd);
            wr_pend = outputMemoryWriteReq && !outputMemoryWriteAck;
            wr_pend_addr = int'(outputMemoryWriteAdd);
            wr_pend_data = outputMemoryWriteData;
            cmd_pend = register32CmdReq && !register32CmdAck;
            cmd_pend_addr = register32Address;
            cmd_pend_we = register32WriteEn;
        end
    end

    task automatic launch(input job_t j);
        logic [31:0] sum, w, r;
        wr_q.delete(); rd_q.delete(); rd_log.delete();
        rd_acked = 0; wr_acked = 0; clears = 0; viol = 0; max_out = 0;
        reg4_writes = 0; reg4_val = '0; reg4_addr = 0; first_wr = -1; last_wr = -1;
        cfg[0] = 32'(j.n); cfg[1] = 32'(j.src); cfg[2] = 32'(j.dst);
        cfg[3] = {16'(j.k), 14'd0, 2'(j.mode)};
        slow = j.slow;
        sum = '0;
        for (int i = 0; i < j.n; i++) begin
            w = mem_word((j.src + i) & INMASK);
            sum += w;
            case (j.mode)
                1:       r = w + 32'(j.k & 32'hFFFF);
                2:       r = sum;
                3:       r = w ^ 32'(j.k & 32'hFFFF);
                default: r = w;
            endcase
            rd_q.push_back((j.src + i) & INMASK);
            wr_q.push_back('{addr: (j.dst + i) & OUTMASK, data: r});
        end
        @(posedge clk); #1 userRunValue = 1'b1;
        @(posedge clk); #1 userRunValue = 1'b0;
    endtask

    task automatic run_job(input job_t j, input string tag);
        launch(j);
        for (int c = 0; c < 3000 && clears == 0; c++) begin
            @(posedge clk); #1;
            userRunValue = j.slow && (c == 10);   // ignored outside IDLE
        end
        userRunValue = 1'b0;
        if (clears == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
        chk({tag, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        chk({tag, "_wr_count"}, 64'(wr_acked), 64'(j.n));
        chk({tag, "_rd_count"}, 64'(rd_acked), 64'(j.n));
        chk({tag, "_reg4_val"}, 64'(reg4_val), 64'(j.exp_reg4));
        chk({tag, "_reg4_addr"}, 64'(reg4_addr), 64'd4);
        chk({tag, "_reg4_writes"}, 64'(reg4_writes), 64'd1);
        chk({tag, "_clear_pulses"}, 64'(clears), 64'(j.exp_clears));
        chk({tag, "_hold_viol"}, 64'(viol), 64'd0);
        checks++;
        if (max_out > FIFO_DEPTH) begin
            errors++;
            $display("FAIL %s_outstanding actual=%0d limit=%0d", tag, max_out, FIFO_DEPTH);
        end
        if (!j.slow && j.n >= 2) chk({tag, "_throughput"}, 64'(last_wr - first_wr), 64'(j.n - 1));
    endtask

    job_t jobs[8];

    initial begin
        logic [31:0] exp_sum[4];
        jobs[0] = '{n: 4,  src: 'h10,    dst: 'h20,   mode: 0, k: 0,      slow: 0, exp_reg4: 4,  exp_clears: 1};
        jobs[1] = '{n: 4,  src: 'h40,    dst: 'h60,   mode: 2, k: 0,      slow: 0, exp_reg4: 4,  exp_clears: 1};
        jobs[2] = '{n: 1,  src: 'h80,    dst: 'h90,   mode: 1, k: 5,      slow: 0, exp_reg4: 1,  exp_clears: 1};
        jobs[3] = '{n: 0,  src: 'h88,    dst: 'h98,   mode: 0, k: 0,      slow: 0, exp_reg4: 0,  exp_clears: 1};
        jobs[4] = '{n: 20, src: 'h100,   dst: 'h200,  mode: 3, k: 'hBEEF, slow: 1, exp_reg4: 20, exp_clears: 1};
        jobs[5] = '{n: 4,  src: 'h1FFFE, dst: 'h1FFE, mode: 1, k: 'h1234, slow: 0, exp_reg4: 4,  exp_clears: 1};
        jobs[6] = '{n: 16, src: 'h300,   dst: 'h400,  mode: 2, k: 0,      slow: 0, exp_reg4: 16, exp_clears: 1};
        jobs[7] = '{n: 8,  src: 'h600,   dst: 'h700,  mode: 1, k: 'h77,   slow: 0, exp_reg4: 8,  exp_clears: 1};
        for (int i = 0; i < 4; i++) ovr['h40 + i] = 32'(i + 1);
        ovr['h80] = 32'hFFFF_FFFF;
        exp_sum[0] = 32'd1; exp_sum[1] = 32'd3; exp_sum[2] = 32'd6; exp_sum[3] = 32'd10;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs_zero", 64'(|{userRunClear, register32CmdReq, register32WriteData, register32Address,
            register32WriteEn, inputMemoryReadReq, inputMemoryReadAdd, outputMemoryWriteReq,
            outputMemoryWriteAdd, outputMemoryWriteData, LED}), 64'd0);
        chk("rst_bytemask", 64'(outputMemoryWriteByteMask), 64'hF);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(jobs[i], $sformatf("job%0d", i));
            if (i == 1)
                for (int w = 0; w < 4; w++) chk($sformatf("runsum%0d", w), 64'(out_log['h60 + w]), 64'(exp_sum[w]));
            if (i == 2) chk("add_k_wrap", 64'(out_log['h90]), 64'h4);
            if (i == 5) begin
                chk("wrap_rd0", 64'(rd_log.size() > 0 ? rd_log[0] : -1), 64'h1FFFE);
                chk("wrap_rd1", 64'(rd_log.size() > 1 ? rd_log[1] : -1), 64'h1FFFF);
                chk("wrap_rd2", 64'(rd_log.size() > 2 ? rd_log[2] : -1), 64'h0);
                chk("wrap_rd3", 64'(rd_log.size() > 3 ? rd_log[3] : -1), 64'h1);
            end
        end

        // Abandon a long job mid-stream with an asynchronous reset.
        launch('{n: 32, src: 'h500, dst: 'h580, mode: 0, k: 0, slow: 0, exp_reg4: 32, exp_clears: 1});
        for (int c = 0; c < 500 && wr_acked < 5; c++) @(posedge clk);
        #1;
        chk("midrun_reached_run", 64'(wr_acked >= 5), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrun_outs_zero", 64'(|{userRunClear, register32CmdReq, register32WriteData, register32Address,
            register32WriteEn, inputMemoryReadReq, inputMemoryReadAdd, outputMemoryWriteReq,
            outputMemoryWriteAdd, outputMemoryWriteData, LED}), 64'd0);
        chk("midrun_bytemask", 64'(outputMemoryWriteByteMask), 64'hF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(register32CmdReq | inputMemoryReadReq | outputMemoryWriteReq), 64'd0);
        run_job(jobs[7], "job7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
